// File: rtl/cs_window_engine.sv
// Sliding-window selector: keeps the last N samples and, once full, scans them
// to pick the sample nearest the window average and emit (sum + N*xa) >> SHIFT.
module cs_window_engine #(
    parameter  int W     = 8,
    parameter  int N     = 9,
    parameter  int SHIFT = 3,
    localparam int SW    = W + $clog2(N) + 1,
    localparam int YW    = SW - SHIFT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [W-1:0]  X,
    input  logic          x_valid,
    input  logic          mode,
    output logic          x_ready,
    output logic [YW-1:0] Y,
    output logic          y_valid
);

    localparam int PW = $clog2(N);
    localparam int FW = $clog2(N + 1);
    localparam logic [SW-1:0] NV = SW'(N);

    typedef enum logic [1:0] {IDLE, SCAN, OUT} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [W-1:0]  win [N];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] idx;
    logic [FW-1:0] fill;
    logic [SW-1:0] sum;
    logic          mode_q;
    logic          found;
    logic [W-1:0]  best;

    logic          acc;
    logic          full;
    logic          fills;
    logic          last;
    logic [W-1:0]  cur;
    logic [SW-1:0] nx;
    logic          qual;
    logic          better;
    logic [W-1:0]  sel;
    logic [SW-1:0] total;

    assign acc   = x_valid && x_ready;
    assign full  = (fill == FW'(N));
    assign fills = acc && (fill >= FW'(N - 1));
    assign last  = (idx == PW'(N - 1));
    assign cur   = win[idx];

    // Compare N*xi against the sum so no division is needed.
    assign nx     = NV * SW'(cur);
    assign qual   = mode_q ? (nx >= sum) : (nx <= sum);
    assign better = !found || (mode_q ? (cur < best) : (cur > best));
    assign sel    = (qual && better) ? cur : best;
    assign total  = sum + NV * SW'(sel);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (fills) state_nxt = SCAN;
            SCAN:    if (last) state_nxt = OUT;
            OUT:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        x_ready = (state == IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                win[i] <= '0;
            end
            wr_ptr  <= '0;
            idx     <= '0;
            fill    <= '0;
            sum     <= '0;
            mode_q  <= 1'b0;
            found   <= 1'b0;
            best    <= '0;
            Y       <= '0;
            y_valid <= 1'b0;
        end else begin
            y_valid <= 1'b0;
            if (acc) begin
                win[wr_ptr] <= X;
                wr_ptr <= (wr_ptr == PW'(N - 1)) ? '0 : wr_ptr + PW'(1);
                sum <= sum + SW'(X) - (full ? SW'(win[wr_ptr]) : '0);
                if (!full) begin
                    fill <= fill + FW'(1);
                end
                if (fills) begin
                    mode_q <= mode;
                    idx    <= '0;
                    found  <= 1'b0;
                end
            end
            // The final entry is folded in combinationally so Y lands with OUT.
            if (state == SCAN) begin
                best  <= sel;
                found <= found | qual;
                idx   <= idx + PW'(1);
                if (last) begin
                    Y       <= total[SW-1:SHIFT];
                    y_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cs_window_engine.sv
// Bench for cs_window_engine: queue-based window model, per-cycle compare,
// directed literal cases and randomized traffic.
module tb_cs_window_engine;

    localparam int W     = 8;
    localparam int N     = 9;
    localparam int SHIFT = 3;
    localparam int YW    = W + $clog2(N) + 1 - SHIFT;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [W-1:0]  X = '0;
    logic          x_valid = 1'b0;
    logic          mode = 1'b0;
    logic          x_ready;
    logic [YW-1:0] Y;
    logic          y_valid;

    cs_window_engine #(.W(W), .N(N), .SHIFT(SHIFT)) dut (
        .clk     (clk),
        .reset   (reset),
        .X       (X),
        .x_valid (x_valid),
        .mode    (mode),
        .x_ready (x_ready),
        .Y       (Y),
        .y_valid (y_valid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;

    int win[$];
    int e = 0;
    int busy_until = -1;
    bit pend_has = 0;
    int pend_due = 0;
    int pend_y = 0;
    int model_last = 0;
    bit exp_ready = 1;
    bit exp_valid = 0;
    int exp_y = 0;
    bit chk_en = 0;
    int dut_last_y = 0;
    int dut_pulses = 0;

    task automatic chk(input string name, input int got, input int want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, want, $time);
    endtask

    function automatic int model_y(input bit m);
        int s = 0;
        int xa = -1;
        foreach (win[i]) s += win[i];
        foreach (win[i]) begin
            if (m == 1'b0) begin
                if (N * win[i] <= s && (xa < 0 || win[i] > xa)) xa = win[i];
            end else begin
                if (N * win[i] >= s && (xa < 0 || win[i] < xa)) xa = win[i];
            end
        end
        return (s + N * xa) >> SHIFT;
    endfunction

    task automatic step(input bit v, input int x, input bit m, input bit r);
        bit acc;
        reset = r;
        x_valid = v;
        X = W'(x);
        mode = m;
        acc = v && exp_ready && !r;
        @(posedge clk);
        e++;
        if (r) begin
            win.delete();
            pend_has = 0;
            busy_until = -1;
            exp_y = 0;
        end else if (acc) begin
            win.push_back(x);
            if (win.size() > N) void'(win.pop_front());
            if (win.size() == N) begin
                pend_has = 1;
                pend_due = e + N;
                pend_y = model_y(m);
                model_last = pend_y;
                busy_until = e + N;
            end
        end
        exp_valid = pend_has && (pend_due == e);
        if (exp_valid) begin
            exp_y = pend_y;
            pend_has = 0;
        end
        exp_ready = (e > busy_until);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, $urandom_range(0, 255), $urandom_range(0, 1), 0);
    endtask

    task automatic feed(input int x, input bit m);
        int k = 0;
        while (!exp_ready && k < 50) begin
            step(0, 0, 0, 0);
            k++;
        end
        if (!exp_ready) begin
            n_checks++;
            $display("FAIL feed_timeout: got busy expected ready");
        end
        step(1, x, m, 0);
    endtask

    task automatic do_reset();
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
    endtask

    task automatic result_lit(input string name, input int want);
        int p0 = dut_pulses;
        idle(N + 2);
        chk({name, "_pulses"}, dut_pulses - p0, 1);
        chk({name, "_dut"}, dut_last_y, want);
        chk({name, "_model"}, model_last, want);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("x_ready", int'(x_ready), int'(exp_ready));
            chk("y_valid", int'(y_valid), int'(exp_valid));
            chk("Y", int'(Y), exp_y);
            if (y_valid) begin
                dut_last_y = int'(Y);
                dut_pulses++;
            end
        end
    end

    initial begin
        int p0;
        @(negedge clk);
        do_reset();
        chk_en = 1;
        chk("reset_Y", int'(Y), 0);
        chk("reset_y_valid", int'(y_valid), 0);
        chk("reset_x_ready", int'(x_ready), 1);

        for (int i = 1; i <= 8; i++) feed(i, 0);
        p0 = dut_pulses;
        feed(9, 0);
        chk("warmup_no_pulse", dut_pulses - p0, 0);
        // Hold valid high while busy; nothing may be consumed.
        for (int i = 0; i < N + 1; i++) step(1, 200, 0, 0);
        chk("first_pulses", dut_pulses - p0, 1);
        chk("first_dut", dut_last_y, 11);
        chk("first_model", model_last, 11);
        feed(10, 0);
        result_lit("slide", 13);

        do_reset();
        for (int i = 0; i < 8; i++) feed(0, 0);
        feed(100, 0);
        result_lit("mode0", 12);
        do_reset();
        for (int i = 0; i < 8; i++) feed(0, 1);
        feed(100, 1);
        result_lit("mode1", 125);

        do_reset();
        for (int i = 0; i < 9; i++) feed(255, 0);
        result_lit("max_m0", 573);
        feed(255, 1);
        result_lit("max_m1", 573);
        do_reset();
        for (int i = 0; i < 9; i++) feed(7, 0);
        result_lit("eq_m0", 15);
        feed(7, 1);
        result_lit("eq_m1", 15);

        do_reset();
        for (int i = 1; i <= 9; i++) feed(i, 0);
        idle(3);
        p0 = dut_pulses;
        step(0, 0, 0, 1);
        idle(14);
        chk("abort_no_pulse", dut_pulses - p0, 0);
        for (int i = 1; i <= 8; i++) feed(i, 0);
        idle(N + 3);
        chk("abort_fill_cleared", dut_pulses - p0, 0);
        feed(9, 0);
        result_lit("after_abort", 11);

        for (int i = 0; i < 1500; i++) begin
            int x;
            x = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 255) : $urandom_range(4, 6);
            step($urandom_range(0, 3) != 0, x, $urandom_range(0, 1),
                 $urandom_range(0, 299) == 0);
        end
        idle(N + 3);

        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
